rr_timeout_arbiter: RTL

//  N-port round-robin NoC output arbiter with per-port packet-length timeout.

---
 rtl/noc_arb_pkg.sv | 38 +++
 rtl/arb_port_timer.sv | 53 +++++
 rtl/rr_timeout_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants, port-index type and the round-robin search used by rr_timeout_arbiter.
package noc_arb_pkg;

    localparam int unsigned FID_W_DEF     = 3;
    localparam int unsigned LEN_W_DEF     = 12;
    localparam logic [2:0]  HEADER_ID_DEF = 3'b001;
    localparam int unsigned MAX_PORTS     = 32;

    typedef logic [4:0] port_idx_t;

    // One-hot first requester at or after start, wrapping within the n active ports.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input port_idx_t            start,
                                                     input int unsigned          n);
        logic [MAX_PORTS-1:0] pick;
        logic                 found;
        int unsigned          idx;
        pick  = '0;
        found = 1'b0;
        idx   = 32'd0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            idx = 32'(start) + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k < n) && !found && req[idx[4:0]]) begin
                pick[idx[4:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_port_timer.sv
// Per-port packet-length limit and grant-age counter; only built when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_port_timer
    import noc_arb_pkg::*;
#(
    parameter int unsigned      LEN_W     = LEN_W_DEF,
    parameter int unsigned      FID_W     = FID_W_DEF,
    parameter logic [FID_W-1:0] HEADER_ID = FID_W'(HEADER_ID_DEF)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [FID_W-1:0] flit_id_i,
    input  logic [LEN_W-1:0] length_i,
    output logic             timesup_o
);

    logic [LEN_W-1:0] limit_q, limit_d;
    logic [LEN_W-1:0] count_q, count_d;

    // Header latches a new limit; the age counter runs only while the grant is held and saturates.
    always_comb begin
        limit_d = limit_q;
        count_d = '0;
        if (flit_id_i == HEADER_ID) begin
            limit_d = length_i;
        end else begin
            limit_d = limit_q;
        end
        if (!run_i) begin
            count_d = '0;
        end else if (count_q == '1) begin
            count_d = count_q;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Limit and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            limit_q <= '0;
            count_q <= '0;
        end else begin
            limit_q <= limit_d;
            count_q <= count_d;
        end
    end

    assign timesup_o = (limit_q != '0) && (count_q == limit_q);

endmodule
`endif

// File: rtl/rr_timeout_arbiter.sv
// N-port round-robin output arbiter with per-port packet-length timeout.
// Timeout logic is present only when ARB_TIMEOUT_EN is defined; otherwise grants hold until req drops.
module rr_timeout_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned      NPORTS    = 5,
    parameter int unsigned      LEN_W     = LEN_W_DEF,
    parameter int unsigned      FID_W     = FID_W_DEF,
    parameter logic [FID_W-1:0] HEADER_ID = FID_W'(HEADER_ID_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       req,
    input  logic [NPORTS*FID_W-1:0] flit_id,
    input  logic [NPORTS*LEN_W-1:0] length,
    output logic [NPORTS-1:0]       grant,
    output logic [NPORTS-1:0]       timeout_p
);

    logic [NPORTS-1:0]    grant_q, grant_d;
    logic [NPORTS-1:0]    timeout_q, timeout_d;
    logic [NPORTS-1:0]    run_s, timesup_s;
    port_idx_t            ptr_q, ptr_d;
    port_idx_t            cur_s, nxt_s;
    logic [MAX_PORTS-1:0] idle_pick_s, rel_pick_s;
    logic                 onehot_s, own_req_s, own_tu_s;
    logic                 unused_s;

    // Index of the current owner (grant_q is one-hot whenever this is consumed).
    always_comb begin
        cur_s = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                cur_s = port_idx_t'(i);
            end else begin
                cur_s = cur_s;
            end
        end
    end

    assign onehot_s    = ((grant_q & (grant_q - 1'b1)) == '0);
    assign own_req_s   = |(req & grant_q);
    assign own_tu_s    = |(timesup_s & grant_q);
    assign nxt_s       = (cur_s == port_idx_t'(NPORTS - 1)) ? 5'd0 : (cur_s + 5'd1);
    assign idle_pick_s = rr_pick(MAX_PORTS'(req), ptr_q, NPORTS);
    // Search starts after the owner, so the owner itself comes last and wins only when alone.
    assign rel_pick_s  = rr_pick(MAX_PORTS'(req), nxt_s, NPORTS);

    // Next grant, pointer and timeout pulse; a corrupted (multi-hot) grant falls back to IDLE.
    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        timeout_d = '0;
        run_s     = '0;
        if (grant_q == '0) begin
            grant_d = idle_pick_s[NPORTS-1:0];
        end else if (!onehot_s) begin
            grant_d = '0;
        end else if (own_req_s && !own_tu_s) begin
            run_s = grant_q;
        end else begin
            grant_d   = rel_pick_s[NPORTS-1:0];
            ptr_d     = nxt_s;
            timeout_d = grant_q & req & timesup_s;
        end
    end

    // Grant (the FSM state), round-robin pointer and timeout pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= '0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    for (genvar i = 0; i < NPORTS; i++) begin : g_timer
        arb_port_timer #(
            .LEN_W     (LEN_W),
            .FID_W     (FID_W),
            .HEADER_ID (HEADER_ID)
        ) u_timer (
            .clk_i     (clk),
            .rst_ni    (rst),
            .run_i     (run_s[i]),
            .flit_id_i (flit_id[i*FID_W +: FID_W]),
            .length_i  (length[i*LEN_W +: LEN_W]),
            .timesup_o (timesup_s[i])
        );
    end
    assign unused_s = ^{idle_pick_s, rel_pick_s};
`else
    assign timesup_s = '0;
    assign unused_s  = ^{idle_pick_s, rel_pick_s, flit_id, length, HEADER_ID, run_s};
`endif

    assign grant     = grant_q;
    assign timeout_p = timeout_q;

endmodule
